fft64_frame_seq: RTL and testbench

//  Frame sequencer for the USFFT64_2B core. Accepts a valid/ready sample stream and issues START/ED
//  to the core, one 64-point frame at a time (no frame overlap). Flushes the pipeline and returns
//  64 results with index/last markers. Runs block-floating-point SHIFT control from OVF1/OVF2.

---
 rtl/fft64_frame_seq_if.sv | 46 ++++
 rtl/fft64_frame_seq.sv | 171 +++++++++++++++++
 tb/tb_fft64_frame_seq.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft64_frame_seq_if.sv
// Signal bundle between the frame sequencer, its sample/result streams and the USFFT64_2B core.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface fft64_frame_seq_if;
  logic        enable;
  logic        auto_scale;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_re;
  logic [15:0] in_im;
  logic        out_ready;
  logic        out_valid;
  logic [18:0] out_re;
  logic [18:0] out_im;
  logic [5:0]  out_idx;
  logic        out_last;
  logic        fft_start;
  logic        fft_ed;
  logic [3:0]  fft_shift;
  logic [15:0] fft_dr;
  logic [15:0] fft_di;
  logic        fft_rdy;
  logic        fft_ovf1;
  logic        fft_ovf2;
  logic [5:0]  fft_addr;
  logic [18:0] fft_dor;
  logic [18:0] fft_doi;
  logic        frame_ovf;
  logic [15:0] frame_cnt;
  logic        err_timeout;

  modport slave (
    input  enable, auto_scale, in_valid, in_re, in_im, out_ready,
    input  fft_rdy, fft_ovf1, fft_ovf2, fft_addr, fft_dor, fft_doi,
    output in_ready, out_valid, out_re, out_im, out_idx, out_last,
    output fft_start, fft_ed, fft_shift, fft_dr, fft_di,
    output frame_ovf, frame_cnt, err_timeout
  );

  modport master (
    output enable, auto_scale, in_valid, in_re, in_im, out_ready,
    output fft_rdy, fft_ovf1, fft_ovf2, fft_addr, fft_dor, fft_doi,
    input  in_ready, out_valid, out_re, out_im, out_idx, out_last,
    input  fft_start, fft_ed, fft_shift, fft_dr, fft_di,
    input  frame_ovf, frame_cnt, err_timeout
  );
endinterface

// File: rtl/fft64_frame_seq.sv
// Runs USFFT64_2B one frame at a time: START, 64 loaded samples, drain of 64 tagged results (combinational).
// No result storage: out_ready gates core ED, so backpressure stalls the core rather than dropping data.
module fft64_frame_seq #(
  parameter logic [3:0] SHIFT_INIT   = 4'd0,
  parameter logic [3:0] SHIFT_MAX    = 4'd15,
  parameter int         CLEAN_FRAMES = 4,
  parameter int         TIMEOUT      = 255
) (
  input logic              CLK,
  input logic              RST,
  fft64_frame_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, LOAD, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [5:0]  in_cnt_q, in_cnt_d;
  logic [5:0]  out_cnt_q, out_cnt_d;
  logic [7:0]  wd_cnt_q, wd_cnt_d;
  logic        out_act_q, out_act_d;
  logic        ovf_seen_q, ovf_seen_d;
  logic [3:0]  shift_q, shift_d;
  logic [7:0]  clean_cnt_q, clean_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        err_q, err_d;

  logic        start_go;
  logic        in_rdy;
  logic        ed;
  logic        start;
  logic [15:0] dr;
  logic [15:0] di;
  logic        accept;
  logic        out_vld;
  logic        last;
  logic        ovf_hit;

  always_comb begin
    start_go    = bus.enable & bus.in_valid & ~err_q;
    in_rdy      = 1'b0;
    ed          = 1'b0;
    start       = 1'b0;
    dr          = '0;
    di          = '0;
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    out_act_d   = out_act_q;
    ovf_seen_d  = ovf_seen_q;
    shift_d     = shift_q;
    clean_cnt_d = clean_cnt_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;

    case (state_q)
      START: begin
        start = 1'b1;
        ed    = 1'b1;
      end
      LOAD: begin
        in_rdy = bus.out_ready;
        ed     = bus.in_valid & bus.out_ready;
        if (ed) begin
          dr = bus.in_re;
          di = bus.in_im;
        end
      end
      DRAIN:   ed = bus.out_ready;
      default: ;
    endcase

    accept  = bus.in_valid & in_rdy;
    out_vld = ed & (bus.fft_rdy | out_act_q);
    last    = out_vld & (out_cnt_q == 6'd63);
    ovf_hit = ovf_seen_q | ((bus.fft_ovf1 | bus.fft_ovf2) & ed);

    if ((bus.fft_ovf1 | bus.fft_ovf2) & ed) ovf_seen_d = 1'b1;
    if (ed & bus.fft_rdy)                   out_act_d  = 1'b1;
    if (out_vld)                            out_cnt_d  = out_cnt_q + 6'd1;

    case (state_q)
      IDLE:  if (start_go) state_d = START;
      START: begin
        state_d  = LOAD;
        in_cnt_d = '0;
        wd_cnt_d = '0;
      end
      LOAD: begin
        if (accept) begin
          in_cnt_d = in_cnt_q + 6'd1;
          if (in_cnt_q == 6'd63) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Watchdog only runs while the core has not yet signalled RDY.
        if (ed & ~bus.fft_rdy & ~out_act_q) begin
          if (wd_cnt_q == 8'(TIMEOUT - 1)) begin
            err_d      = 1'b1;
            ovf_seen_d = 1'b0;
            state_d    = IDLE;
          end else begin
            wd_cnt_d = wd_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (last) begin
      out_act_d   = 1'b0;
      ovf_seen_d  = 1'b0;
      frame_cnt_d = frame_cnt_q + 16'd1;
      state_d     = start_go ? START : IDLE;
      // SHIFT only moves between frames, so the core never sees a mid-frame change.
      if (bus.auto_scale) begin
        if (ovf_hit) begin
          shift_d     = (shift_q >= SHIFT_MAX) ? SHIFT_MAX : shift_q + 4'd1;
          clean_cnt_d = '0;
        end else if (clean_cnt_q + 8'd1 >= 8'(CLEAN_FRAMES)) begin
          shift_d     = (shift_q > SHIFT_INIT) ? shift_q - 4'd1 : SHIFT_INIT;
          clean_cnt_d = '0;
        end else begin
          clean_cnt_d = clean_cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      wd_cnt_q    <= '0;
      out_act_q   <= 1'b0;
      ovf_seen_q  <= 1'b0;
      shift_q     <= SHIFT_INIT;
      clean_cnt_q <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      out_act_q   <= out_act_d;
      ovf_seen_q  <= ovf_seen_d;
      shift_q     <= shift_d;
      clean_cnt_q <= clean_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready    = in_rdy;
  assign bus.fft_start   = start;
  assign bus.fft_ed      = ed;
  assign bus.fft_shift   = shift_q;
  assign bus.fft_dr      = dr;
  assign bus.fft_di      = di;
  assign bus.out_valid   = out_vld;
  assign bus.out_re      = bus.fft_dor;
  assign bus.out_im      = bus.fft_doi;
  assign bus.out_idx     = bus.fft_addr;
  assign bus.out_last    = last;
  assign bus.frame_ovf   = last & ovf_hit;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_fft64_frame_seq.sv
// Bench for fft64_frame_seq with a stub core that echoes loaded samples as results after a short latency.
module tb_fft64_frame_seq;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  fft64_frame_seq_if bus ();
  fft64_frame_seq dut (.CLK(CLK), .RST(RST), .bus(bus));

  typedef struct packed {
    logic [18:0] re;
    logic [18:0] im;
    logic [5:0]  idx;
    logic        last;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0, n_fail = 0;
  int   n_last = 0, n_start = 0, n_acc = 0, last_cyc = 0, cyc = 0;
  bit   chk_b2b = 0, core_dead = 0;
  logic [3:0] sh_start = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stub core: START resets, 64 ED cycles load, 4 ED cycles latency, then 64 results on ED.
  int          cm_mode = 0, ld = 0, lat = 0, oc = 0;
  logic [15:0] mem_re[64];
  logic [15:0] mem_im[64];
  always @(posedge CLK) begin
    if (bus.fft_start) begin
      cm_mode <= 1;
      ld      <= 0;
    end else if (bus.fft_ed) begin
      case (cm_mode)
        1: begin
          mem_re[ld] <= bus.fft_dr;
          mem_im[ld] <= bus.fft_di;
          ld <= ld + 1;
          if (ld == 63) begin cm_mode <= 2; lat <= 0; end
        end
        2: if (!core_dead) begin
          if (lat == 3) begin cm_mode <= 3; oc <= 0; end
          else lat <= lat + 1;
        end
        3: begin
          oc <= oc + 1;
          if (oc == 63) cm_mode <= 0;
        end
        default: ;
      endcase
    end
  end
  assign bus.fft_rdy  = (cm_mode == 3) && (oc == 0);
  assign bus.fft_addr = oc[5:0];
  assign bus.fft_dor  = {{3{mem_re[oc[5:0]][15]}}, mem_re[oc[5:0]]};
  assign bus.fft_doi  = {{3{mem_im[oc[5:0]][15]}}, mem_im[oc[5:0]]};
  assign bus.fft_ovf1 = bus.fft_ed && (bus.fft_dr == 16'h7FFF);
  assign bus.fft_ovf2 = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor / scoreboard
  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      check("dr_gate", bus.fft_dr, (bus.in_valid && bus.in_ready) ? bus.in_re : 16'd0);
      if (bus.fft_start) begin
        n_start++;
        sh_start = bus.fft_shift;
        if (chk_b2b) check("b2b_start_cycle", cyc, last_cyc + 1);
      end
      if (bus.in_valid && bus.in_ready) n_acc++;
      if (bus.out_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("out_re", bus.out_re, e.re);
          check("out_im", bus.out_im, e.im);
          check("out_idx", bus.out_idx, e.idx);
          check("out_last", bus.out_last, e.last);
          check("frame_ovf", bus.frame_ovf, e.ovf);
        end
        check("shift_stable", bus.fft_shift, sh_start);
        if (bus.out_last) begin
          n_last++;
          last_cyc = cyc;
        end
      end else begin
        check("frame_ovf_idle", bus.frame_ovf, 0);
      end
    end
  end

  function automatic logic [15:0] pat_re(input int p, input int i);
    case (p)
      0:       return 16'(i);
      1:       return 16'h7FFF;
      default: return 16'(-3 * i);
    endcase
  endfunction

  function automatic logic [15:0] pat_im(input int p, input int i);
    case (p)
      0:       return 16'd0;
      1:       return 16'(-i);
      default: return 16'(100 * i);
    endcase
  endfunction

  function automatic logic [18:0] sx(input logic [15:0] v);
    return {{3{v[15]}}, v};
  endfunction

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic run_frame(input int pat, input bit toggle, input bit keep, input bit exp_ovf);
    int   k, c, s0, l0;
    bit   started;
    exp_t e;
    for (int i = 0; i < 64; i++) begin
      e.re   = sx(pat_re(pat, i));
      e.im   = sx(pat_im(pat, i));
      e.idx  = 6'(i);
      e.last = (i == 63);
      e.ovf  = exp_ovf && (i == 63);
      sb_q.push_back(e);
    end
    k = 0; c = 0; started = 0; s0 = n_start; l0 = n_last;
    while (n_last == l0 && c < 3000) begin
      bus.in_valid  = (k < 64) || keep;
      bus.in_re     = pat_re(pat, k % 64);
      bus.in_im     = pat_im(pat, k % 64);
      bus.out_ready = toggle ? (c % 2 == 0) : 1'b1;
      @(negedge CLK);
      if (started && !bus.fft_start)
        check("ed_follow", bus.fft_ed,
              (k < 64) ? (bus.in_valid && bus.out_ready) : bus.out_ready);
      if (bus.fft_start) started = 1;
      if (bus.in_valid && bus.in_ready) k++;
      @(posedge CLK);
      #1 c++;
    end
    check("frame_done", n_last - l0, 1);
    check("accepts", k, 64);
    check("starts", n_start - s0, 1);
    if (!keep) bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k, c, dcnt, s0, a0;
    RST = 1'b1;
    bus.enable = 0; bus.auto_scale = 0; bus.in_valid = 0;
    bus.in_re = '0; bus.in_im = '0; bus.out_ready = 0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    // Reset state
    @(negedge CLK);
    check("rst_shift", bus.fft_shift, 0);
    check("rst_frame_cnt", bus.frame_cnt, 0);
    check("rst_err", bus.err_timeout, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_ed", bus.fft_ed, 0);
    check("rst_start", bus.fft_start, 0);

    // enable low holds IDLE even with valid input
    @(posedge CLK); #1;
    bus.in_valid = 1; s0 = n_start;
    repeat (5) @(posedge CLK);
    #1 check("no_start_disabled", n_start - s0, 0);
    bus.in_valid = 0;

    // 1: single frame, ramp input
    bus.enable = 1; bus.out_ready = 1;
    run_frame(0, 0, 0, 0);
    check("frame_cnt_1", bus.frame_cnt, 1);
    repeat (3) @(posedge CLK);
    #1;

    // 2: out_ready toggling every cycle
    run_frame(0, 1, 0, 0);
    check("frame_cnt_2", bus.frame_cnt, 2);

    // 3: overflow raises SHIFT, four clean frames lower it
    bus.auto_scale = 1;
    run_frame(1, 0, 0, 1);
    check("shift_after_ovf", bus.fft_shift, 1);
    for (int f = 0; f < 4; f++) begin
      run_frame((f % 2 == 0) ? 0 : 2, 0, 0, 0);
      check("shift_clean", bus.fft_shift, (f < 3) ? 1 : 0);
    end
    bus.auto_scale = 0;
    run_frame(1, 0, 0, 1);
    check("shift_hold_no_auto", bus.fft_shift, 0);
    check("frame_cnt_8", bus.frame_cnt, 8);

    // 6: three back-to-back frames
    do_reset();
    check("frame_cnt_after_rst", bus.frame_cnt, 0);
    a0 = n_acc;
    run_frame(2, 0, 1, 0);
    chk_b2b = 1;
    run_frame(2, 0, 1, 0);
    run_frame(2, 0, 0, 0);
    chk_b2b = 0;
    check("frame_cnt_3", bus.frame_cnt, 3);
    check("accepts_3_frames", n_acc - a0, 192);

    // 4: core never reports RDY
    core_dead = 1;
    k = 0; c = 0; dcnt = 0;
    while (!bus.err_timeout && c < 600) begin
      bus.in_valid = 1; bus.in_re = 16'(k); bus.in_im = 16'd0;
      @(negedge CLK);
      if (bus.in_valid && bus.in_ready) k++;
      else if (bus.fft_ed && !bus.fft_start) dcnt++;
      @(posedge CLK);
      #1 c++;
    end
    check("timeout_err", bus.err_timeout, 1);
    check("timeout_drain_cycles", dcnt, 255);
    check("timeout_loaded", k, 64);
    s0 = n_start; a0 = n_acc;
    repeat (20) @(posedge CLK);
    #1;
    check("timeout_no_start", n_start - s0, 0);
    check("timeout_no_accept", n_acc - a0, 0);
    check("timeout_sticky", bus.err_timeout, 1);
    check("timeout_frame_cnt", bus.frame_cnt, 3);

    // 5: reset mid-load at in_cnt=30, then a fresh frame
    core_dead = 0;
    bus.in_valid = 0;
    do_reset();
    check("rst_clears_err", bus.err_timeout, 0);
    k = 0; c = 0;
    while (k < 30 && c < 200) begin
      bus.in_valid = 1; bus.in_re = 16'(k);
      @(negedge CLK);
      if (bus.in_valid && bus.in_ready) k++;
      @(posedge CLK);
      #1 c++;
    end
    check("partial_loaded", k, 30);
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("abort_in_ready", bus.in_ready, 0);
    check("abort_ed", bus.fft_ed, 0);
    check("abort_frame_cnt", bus.frame_cnt, 0);
    @(posedge CLK);
    #1;
    run_frame(2, 0, 0, 0);
    check("fresh_frame_cnt", bus.frame_cnt, 1);

    repeat (5) @(posedge CLK);
    #1 check("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
